// File: rtl/display_readback.sv
// rtl/display_readback.sv - 7-segment scan bus readback: debounced per-position code recovery.
// Optional dp-insensitive decode when READBACK_DP_MASK_EN is defined.
module display_readback #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DIGITS-1:0]     Anodes,
  input  logic [7:0]            Cathodes,
  input  logic                  ClearError,
  output logic [4*DIGITS-1:0]   Codes,
  output logic                  FrameValid,
  output logic                  BadPattern
);

  localparam logic [CNT_W-1:0] STABLE   = CNT_W'(STABLE_CYCLES);
  localparam logic [3:0]       CODE_BAD = 4'hE;

  logic [DIGITS-1:0]   anodes_q, anodes_prev_q;
  logic [7:0]          cathodes_q, cathodes_prev_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIGITS-1:0]   seen_q, seen_d, seen_new;
  logic [4*DIGITS-1:0] codes_q, codes_d;
  logic                fv_q, fv_d;
  logic                bad_q, bad_d;
  logic                same, commit;
  logic [3:0]          code;

  // Exact table first; with masking enabled, a dp-only difference falls back to the
  // [7:1] match, so 01001000 stays S. rather than 5-with-dp.
  function automatic logic [3:0] decode(input logic [7:0] c);
    logic [3:0] r;
    case (c)
      8'b00000011: r = 4'd0;
      8'b10011111: r = 4'd1;
      8'b00100101: r = 4'd2;
      8'b00001101: r = 4'd3;
      8'b10011001: r = 4'd4;
      8'b01001001: r = 4'd5;
      8'b01000001: r = 4'd6;
      8'b00011111: r = 4'd7;
      8'b00000001: r = 4'd8;
      8'b01110000: r = 4'd9;
      8'b01100000: r = 4'd10;
      8'b01001000: r = 4'd11;
      8'b11111111: r = 4'd15;
      default: begin
`ifdef READBACK_DP_MASK_EN
        case (c[7:1])
          7'b0000001: r = 4'd0;
          7'b1001111: r = 4'd1;
          7'b0010010: r = 4'd2;
          7'b0000110: r = 4'd3;
          7'b1001100: r = 4'd4;
          7'b0100000: r = 4'd6;
          7'b0001111: r = 4'd7;
          7'b0000000: r = 4'd8;
          7'b0111000: r = 4'd9;
          7'b0110000: r = 4'd10;
          7'b1111111: r = 4'd15;
          default:    r = CODE_BAD;
        endcase
`else
        r = CODE_BAD;
`endif
      end
    endcase
    return r;
  endfunction

  always_comb begin
    same     = (anodes_q == anodes_prev_q) && (cathodes_q == cathodes_prev_q);
    cnt_d    = !same ? CNT_W'(1) : ((cnt_q == STABLE) ? cnt_q : cnt_q + CNT_W'(1));
    commit   = (cnt_d == STABLE) && ((cnt_q != STABLE) || !same) && $onehot(~anodes_q);
    code     = decode(cathodes_q);
    seen_new = seen_q | ~anodes_q;
    codes_d  = codes_q;
    seen_d   = seen_q;
    fv_d     = 1'b0;
    bad_d    = bad_q & ~ClearError;
    if (commit) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (!anodes_q[i]) codes_d[4*i +: 4] = code;
      end
      if (code == CODE_BAD) bad_d = 1'b1;
      if (&seen_new) begin
        fv_d   = 1'b1;
        seen_d = '0;
      end else begin
        seen_d = seen_new;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      anodes_q        <= '1;
      anodes_prev_q   <= '1;
      cathodes_q      <= '1;
      cathodes_prev_q <= '1;
      cnt_q           <= '0;
      seen_q          <= '0;
      codes_q         <= '1;
      fv_q            <= 1'b0;
      bad_q           <= 1'b0;
    end else begin
      anodes_q        <= Anodes;
      anodes_prev_q   <= anodes_q;
      cathodes_q      <= Cathodes;
      cathodes_prev_q <= cathodes_q;
      cnt_q           <= cnt_d;
      seen_q          <= seen_d;
      codes_q         <= codes_d;
      fv_q            <= fv_d;
      bad_q           <= bad_d;
    end
  end

  assign Codes      = codes_q;
  assign FrameValid = fv_q;
  assign BadPattern = bad_q;

endmodule

// File: tb/tb_display_readback.sv
// tb/tb_display_readback.sv - directed bench for display_readback (default and READBACK_DP_MASK_EN builds).
module tb_display_readback;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [3:0]  Anodes;
  logic [7:0]  Cathodes;
  logic        ClearError;
  logic [15:0] Codes;
  logic        FrameValid;
  logic        BadPattern;

  int          total = 0;
  int          nbad  = 0;
  int          fv_count = 0;
  logic [15:0] fv_codes = '0;

  display_readback #(.DIGITS(4), .STABLE_CYCLES(3), .CNT_W(2)) dut (
    .Clock(Clock), .Reset(Reset), .Anodes(Anodes), .Cathodes(Cathodes),
    .ClearError(ClearError), .Codes(Codes), .FrameValid(FrameValid), .BadPattern(BadPattern)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      nbad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive a pair and run n clocks, sampling 1ns after each rising edge.
  task automatic hold(input logic [3:0] an, input logic [7:0] ca, input int n);
    Anodes   = an;
    Cathodes = ca;
    for (int k = 0; k < n; k++) begin
      @(posedge Clock);
      #1;
      if (FrameValid === 1'b1) begin
        fv_count++;
        fv_codes = Codes;
      end
    end
  endtask

  initial begin
    Reset      = 1'b0;
    Anodes     = 4'b1111;
    Cathodes   = 8'hFF;
    ClearError = 1'b0;
    hold(4'b1111, 8'hFF, 3);
    check("reset_codes", 32'(Codes), 32'hFFFF);
    Reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      hold(4'b1111, 8'hFF, 1);
      check("idle_codes", 32'(Codes), 32'hFFFF);
      check("idle_fv", 32'(FrameValid), 32'h0);
      check("idle_bad", 32'(BadPattern), 32'h0);
    end

    // first full scan 3,0,0,1
    hold(4'b1110, 8'b00001101, 3);
    check("latency_before", 32'(Codes), 32'hFFFF);
    hold(4'b1110, 8'b00001101, 1);
    check("latency_at", 32'(Codes), 32'hFFF3);
    hold(4'b1110, 8'b00001101, 4);
    hold(4'b1101, 8'b00000011, 8);
    hold(4'b1011, 8'b00000011, 8);
    check("no_fv_partial", 32'(fv_count), 32'd0);
    hold(4'b0111, 8'b10011111, 8);
    check("scan1_fv_count", 32'(fv_count), 32'd1);
    check("scan1_fv_codes", 32'(fv_codes), 32'h1003);
    check("scan1_fv_low", 32'(FrameValid), 32'h0);

    // two-cycle glitch must not commit
    hold(4'b1110, 8'b00000011, 2);
    hold(4'b1111, 8'hFF, 6);
    check("glitch_codes", 32'(Codes), 32'h1003);
    check("glitch_fv", 32'(fv_count), 32'd1);

    // bad pattern, clear racing a new bad commit, then clear alone
    hold(4'b1101, 8'b10101010, 6);
    check("bad_slot1", 32'(Codes), 32'h10E3);
    check("bad_set", 32'(BadPattern), 32'h1);
    hold(4'b1111, 8'hFF, 2);
    hold(4'b1101, 8'b10101011, 3);
    ClearError = 1'b1;
    hold(4'b1101, 8'b10101011, 1);
    ClearError = 1'b0;
    check("set_wins", 32'(BadPattern), 32'h1);
    hold(4'b1101, 8'b10101011, 3);
    ClearError = 1'b1;
    hold(4'b1101, 8'b10101011, 1);
    ClearError = 1'b0;
    check("clear_alone", 32'(BadPattern), 32'h0);
    hold(4'b1101, 8'b10101011, 10);
    check("no_recommit", 32'(BadPattern), 32'h0);

    // scan with S. in slot 2; seen already holds slot 1
    hold(4'b1110, 8'b00000011, 8);
    hold(4'b1101, 8'b10011111, 8);
    hold(4'b1011, 8'b01001000, 8);
    check("scan2_partial", 32'(fv_count), 32'd1);
    hold(4'b0111, 8'b01110000, 8);
    check("scan2_fv_count", 32'(fv_count), 32'd2);
    check("scan2_fv_codes", 32'(fv_codes), 32'h9B10);
    check("scan2_bad", 32'(BadPattern), 32'h0);

    // reset in the middle of the next scan
    hold(4'b1110, 8'b10011001, 8);
    check("scan3_slot0", 32'(Codes), 32'h9B14);
    Reset = 1'b0;
    #1;
    check("midreset_codes", 32'(Codes), 32'hFFFF);
    check("midreset_fv", 32'(FrameValid), 32'h0);
    check("midreset_bad", 32'(BadPattern), 32'h0);
    hold(4'b1111, 8'hFF, 3);
    Reset = 1'b1;
    hold(4'b1101, 8'b10011111, 8);
    hold(4'b1011, 8'b00000011, 8);
    hold(4'b0111, 8'b00000011, 8);
    check("post_reset_3commits", 32'(fv_count), 32'd2);
    hold(4'b1110, 8'b00001101, 8);
    check("post_reset_fv_count", 32'(fv_count), 32'd3);
    check("post_reset_fv_codes", 32'(fv_codes), 32'h0013);

    // digit 3 with dp lit
    hold(4'b1111, 8'hFF, 4);
    hold(4'b1110, 8'b00001100, 8);
`ifdef READBACK_DP_MASK_EN
    check("dp_slot0", 32'(Codes[3:0]), 32'h3);
    check("dp_bad", 32'(BadPattern), 32'h0);
`else
    check("dp_slot0", 32'(Codes[3:0]), 32'hE);
    check("dp_bad", 32'(BadPattern), 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule
